led_cnt_multi: RTL and testbench

Parametrised successor to the single-LED counter block. It drives NUM_CH LED outputs from one shared free-running counter. Each channel has its own run-time configuration: mode, blink divisor and PWM duty, loaded through a simple write port with a one-cycle acknowledge. It sits in the PL as a status/indicator block and takes its configuration from a PS-side register slice or a static tie-off.

---
 rtl/led_cnt_pkg.sv | 17 +
 rtl/led_cnt_ch.sv | 64 ++++++
 rtl/led_cnt_multi.sv | 71 +++++++
 tb/tb_led_cnt_multi.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/led_cnt_pkg.sv
// Shared types and helpers for the multi-channel LED indicator block.
// Mode encodings match the two-bit mode field presented on the config write port.
package led_cnt_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_DIM   = 2'd3
    } mode_e;

    // Divisor is a bit index into the shared counter, so it can never exceed its top bit.
    function automatic int clamp_div(input int div, input int cnt_w);
        return (div > cnt_w - 1) ? cnt_w - 1 : div;
    endfunction

endpackage

// File: rtl/led_cnt_ch.sv
// One LED channel: holds its mode/divisor/duty configuration and the registered LED drive.
// The LED register is computed from the configuration already stored, so a write lands one edge later.
module led_cnt_ch
    import led_cnt_pkg::*;
#(
    parameter int CNT_W   = 28,
    parameter int DIV_W   = 5,
    parameter int DIV_RST = 24,
    parameter int PWM_W   = 4
) (
    input  logic             clk100,
    input  logic             rstn,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic             i_wr,
    input  logic [1:0]       i_mode,
    input  logic [DIV_W-1:0] i_div,
    input  logic [PWM_W-1:0] i_duty,
    output logic             o_led
);

    localparam logic [DIV_W-1:0] DIV_RST_C  = DIV_W'(clamp_div(DIV_RST, CNT_W));
    localparam logic [PWM_W-1:0] DUTY_RST_C = PWM_W'(2 ** (PWM_W - 1));

    mode_e            r_mode;
    logic [DIV_W-1:0] r_div;
    logic [PWM_W-1:0] r_duty;
    logic             r_led;

    logic [CNT_W-1:0] w_shifted;
    logic             w_ledNext;

    // A shift keeps the divisor select legal whatever DIV_W is relative to CNT_W.
    assign w_shifted = i_cnt >> r_div;

    always_comb begin
        w_ledNext = 1'b0;
        case (r_mode)
            MODE_OFF:   w_ledNext = 1'b0;
            MODE_ON:    w_ledNext = 1'b1;
            MODE_BLINK: w_ledNext = w_shifted[0];
            MODE_DIM:   w_ledNext = (i_cnt[PWM_W-1:0] < r_duty);
            default:    w_ledNext = 1'b0;
        endcase
    end

    always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn) begin
            r_mode <= MODE_BLINK;
            r_div  <= DIV_RST_C;
            r_duty <= DUTY_RST_C;
            r_led  <= 1'b0;
        end else begin
            if (i_wr) begin
                r_mode <= mode_e'(i_mode);
                r_div  <= DIV_W'(clamp_div(int'(i_div), CNT_W));
                r_duty <= i_duty;
            end
            r_led <= w_ledNext;
        end
    end

    assign o_led = r_led;

endmodule

// File: rtl/led_cnt_multi.sv
// Multi-channel LED indicator: one shared free-running counter drives NUM_CH independently configured LEDs.
// Config writes are acknowledged one cycle later; out-of-range selects are flagged and dropped.
module led_cnt_multi
    import led_cnt_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 28,
    parameter int DIV_W   = 5,
    parameter int DIV_RST = 24,
    parameter int PWM_W   = 4,
    parameter int SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk100,
    input  logic              rstn,
    input  logic              wren_i,
    input  logic [SEL_W-1:0]  ch_sel_i,
    input  logic [1:0]        mode_i,
    input  logic [DIV_W-1:0]  div_i,
    input  logic [PWM_W-1:0]  duty_i,
    output logic              wr_ack_o,
    output logic              wr_err_o,
    output logic [NUM_CH-1:0] led_o
);

    localparam logic [31:0] NUM_CH_U = 32'(NUM_CH);

    logic [CNT_W-1:0]  r_cnt;
    logic              r_ack;
    logic              r_err;
    logic              w_inRange;
    logic [NUM_CH-1:0] w_chWr;

    assign w_inRange = (32'(ch_sel_i) < NUM_CH_U);

    always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
            r_ack <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_ack <= wren_i;
            r_err <= wren_i && !w_inRange;
        end
    end

    assign wr_ack_o = r_ack;
    assign wr_err_o = r_err;

    // An out-of-range select matches no channel, so the write is dropped without extra gating.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_chWr[g] = wren_i && (32'(ch_sel_i) == 32'(g));

        led_cnt_ch #(
            .CNT_W   (CNT_W),
            .DIV_W   (DIV_W),
            .DIV_RST (DIV_RST),
            .PWM_W   (PWM_W)
        ) u_ch (
            .clk100 (clk100),
            .rstn   (rstn),
            .i_cnt  (r_cnt),
            .i_wr   (w_chWr[g]),
            .i_mode (mode_i),
            .i_div  (div_i),
            .i_duty (duty_i),
            .o_led  (led_o[g])
        );
    end

endmodule

// File: tb/tb_led_cnt_multi.sv
// Directed bench for led_cnt_multi with a small 3-channel, 8-bit-counter configuration.
// Expected LED values come from the counter value the bench tracks itself since the last reset release.
module tb_led_cnt_multi;
    import led_cnt_pkg::*;

    localparam int NUM_CH  = 3;
    localparam int CNT_W   = 8;
    localparam int DIV_W   = 5;
    localparam int DIV_RST = 3;
    localparam int PWM_W   = 4;
    localparam int SEL_W   = 2;

    logic              clk100 = 1'b0;
    logic              rstn = 1'b0;
    logic              wren_i = 1'b0;
    logic [SEL_W-1:0]  ch_sel_i = '0;
    logic [1:0]        mode_i = '0;
    logic [DIV_W-1:0]  div_i = '0;
    logic [PWM_W-1:0]  duty_i = '0;
    logic              wr_ack_o;
    logic              wr_err_o;
    logic [NUM_CH-1:0] led_o;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int highs;

    led_cnt_multi #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .DIV_W   (DIV_W),
        .DIV_RST (DIV_RST),
        .PWM_W   (PWM_W),
        .SEL_W   (SEL_W)
    ) dut (
        .clk100   (clk100),
        .rstn     (rstn),
        .wren_i   (wren_i),
        .ch_sel_i (ch_sel_i),
        .mode_i   (mode_i),
        .div_i    (div_i),
        .duty_i   (duty_i),
        .wr_ack_o (wr_ack_o),
        .wr_err_o (wr_err_o),
        .led_o    (led_o)
    );

    always #5 clk100 = ~clk100;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed == expected) passes++;
        else $display("[TB] FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
    endtask

    // Advance one clock and land 1 ns after the edge; cyc counts edges since reset release.
    task automatic tick();
        @(posedge clk100);
        #1;
        cyc++;
    endtask

    task automatic applyStimulus(input int sel, input int mode, input int div, input int duty);
        wren_i   = 1'b1;
        ch_sel_i = SEL_W'(sel);
        mode_i   = 2'(mode);
        div_i    = DIV_W'(div);
        duty_i   = PWM_W'(duty);
        tick();
        wren_i   = 1'b0;
    endtask

    task automatic countHighs(input int ch, input int n, output int h);
        h = 0;
        repeat (n) begin
            tick();
            h += int'(led_o[ch]);
        end
    endtask

    // After c edges, led_o was computed from counter value c-1.
    function automatic int blinkExp(input int c, input int div);
        return ((c - 1) >> div) & 1;
    endfunction

    function automatic int dimExp(input int c, input int duty);
        return (((c - 1) & 15) < duty) ? 1 : 0;
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int b;
        int b0;
        int d2;

        repeat (2) @(posedge clk100);
        #1;
        checkOutput("rst_led", int'(led_o), 0);
        checkOutput("rst_ack", int'(wr_ack_o), 0);
        checkOutput("rst_err", int'(wr_err_o), 0);
        rstn = 1'b1;
        cyc  = 0;

        $display("[TB] reset defaults: all channels blink on counter bit 3");
        for (int k = 0; k < 12; k++) begin
            tick();
            b = blinkExp(cyc, 3);
            checkOutput("dflt_blink", int'(led_o), b ? 7 : 0);
        end

        $display("[TB] asynchronous reset mid-cycle");
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("async_rst_led", int'(led_o), 0);
        tick();
        tick();
        rstn = 1'b1;
        cyc  = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            b = blinkExp(cyc, 3);
            checkOutput("rerun_blink", int'(led_o), b ? 7 : 0);
        end

        $display("[TB] ch1 mode write to ON");
        applyStimulus(1, int'(MODE_ON), 3, 8);
        checkOutput("wr1_ack", int'(wr_ack_o), 1);
        checkOutput("wr1_err", int'(wr_err_o), 0);
        checkOutput("wr1_led1_old", int'(led_o[1]), blinkExp(cyc, 3));
        tick();
        checkOutput("wr1_ack_drop", int'(wr_ack_o), 0);
        b = blinkExp(cyc, 3);
        checkOutput("wr1_led", int'(led_o), (b ? 5 : 0) | 2);
        for (int k = 0; k < 19; k++) begin
            tick();
            b = blinkExp(cyc, 3);
            checkOutput("wr1_led", int'(led_o), (b ? 5 : 0) | 2);
        end

        $display("[TB] divisor clamp and minimum divisor on ch0");
        applyStimulus(0, int'(MODE_BLINK), 31, 0);
        checkOutput("clamp_ack", int'(wr_ack_o), 1);
        countHighs(0, 256, highs);
        checkOutput("clamp_highs256", highs, 128);
        checkOutput("clamp_phase", int'(led_o[0]), blinkExp(cyc, 7));
        applyStimulus(0, int'(MODE_BLINK), 0, 0);
        for (int k = 0; k < 8; k++) begin
            tick();
            checkOutput("div0_toggle", int'(led_o[0]), blinkExp(cyc, 0));
        end

        $display("[TB] DIM duty sweep on ch2");
        applyStimulus(2, int'(MODE_DIM), 0, 0);
        countHighs(2, 64, highs);
        checkOutput("dim_duty0", highs, 0);
        applyStimulus(2, int'(MODE_DIM), 0, 4);
        countHighs(2, 64, highs);
        checkOutput("dim_duty4", highs, 16);
        applyStimulus(2, int'(MODE_DIM), 0, 15);
        countHighs(2, 64, highs);
        checkOutput("dim_duty15", highs, 60);
        checkOutput("dim_phase", int'(led_o[2]), dimExp(cyc, 15));

        $display("[TB] out-of-range channel select");
        applyStimulus(3, int'(MODE_OFF), 0, 0);
        checkOutput("oor_ack", int'(wr_ack_o), 1);
        checkOutput("oor_err", int'(wr_err_o), 1);
        tick();
        checkOutput("oor_ack_drop", int'(wr_ack_o), 0);
        checkOutput("oor_err_drop", int'(wr_err_o), 0);
        for (int k = 0; k < 16; k++) begin
            b0 = blinkExp(cyc, 0);
            d2 = dimExp(cyc, 15);
            checkOutput("oor_unchanged", int'(led_o), b0 | 2 | (d2 << 2));
            tick();
        end

        $display("[TB] back-to-back writes");
        applyStimulus(0, int'(MODE_OFF), 0, 0);
        checkOutput("b2b_ack0", int'(wr_ack_o), 1);
        checkOutput("b2b_err0", int'(wr_err_o), 0);
        applyStimulus(0, int'(MODE_ON), 0, 0);
        checkOutput("b2b_ack1", int'(wr_ack_o), 1);
        checkOutput("b2b_led0_off", int'(led_o[0]), 0);
        applyStimulus(2, int'(MODE_DIM), 0, 8);
        checkOutput("b2b_ack2", int'(wr_ack_o), 1);
        checkOutput("b2b_led0_on", int'(led_o[0]), 1);
        tick();
        checkOutput("b2b_ack_drop", int'(wr_ack_o), 0);
        checkOutput("b2b_led0_hold", int'(led_o[0]), 1);
        countHighs(2, 64, highs);
        checkOutput("b2b_dim50", highs, 32);
        checkOutput("b2b_led0_final", int'(led_o[0]), 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
